// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - nibble-serial adder reusing one 4-bit ripple adder over NIBBLES cycles
// Optional subtraction (sub port, A - B) is built when NIBBLE_SERIAL_SUB_EN is defined.

module ripple_adder (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  logic [4:0] w_c;

  assign w_c[0] = i_cin;
  for (genvar g = 0; g < 4; g++) begin : g_fa
    assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end
  assign o_cout = w_c[4];
endmodule

module nibble_serial_adder_ctrl #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clock,
  input  logic         reset,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic         sub,
`endif
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         cin,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] S,
  output logic         cout,
  output logic         overflow
);
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                      r_state;
  logic [IDXW-1:0]             r_idx;
  logic                        r_carry;
  logic [NIBBLES-1:0][3:0]     r_a;
  logic [NIBBLES-1:0][3:0]     r_b;
  logic [NIBBLES-1:0][3:0]     r_res;

  logic [NIBBLES-1:0][3:0]     w_res_next;
  logic [3:0]                  w_sum;
  logic                        w_cout;
  logic                        w_ovf;
  logic [W-1:0]                w_b_eff;
  logic                        w_c_init;

  ripple_adder u_adder (
    .i_a    (r_a[r_idx]),
    .i_b    (r_b[r_idx]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // r_b already holds the effective (possibly inverted) operand, so overflow uses it directly
  always_comb begin
    w_res_next        = r_res;
    w_res_next[r_idx] = w_sum;
    w_ovf = (r_a[NIBBLES-1][3] == r_b[NIBBLES-1][3]) &&
            (w_res_next[NIBBLES-1][3] != r_a[NIBBLES-1][3]);
  end

`ifdef NIBBLE_SERIAL_SUB_EN
  assign w_b_eff  = sub ? ~B : B;
  assign w_c_init = sub ? 1'b1 : cin;
`else
  assign w_b_eff  = B;
  assign w_c_init = cin;
`endif

  assign ready = (r_state == IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      done     <= 1'b0;
      S        <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= w_b_eff;
            r_carry <= w_c_init;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_res   <= w_res_next;
          r_carry <= w_cout;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LAST) begin
            r_idx    <= '0;
            r_state  <= DONE;
            done     <= 1'b1;
            S        <= w_res_next;
            cout     <= w_cout;
            overflow <= w_ovf;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
NIBBLE_SERIAL_ADDER_CTRL -- requirements
Module: nibble_serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter: NIBBLES, default 4, number of 4-bit slices per operand (legal range 1..8); W = 4*NIBBLES.
REQ-002 The block SHALL have port: clock  input  1  single clock, all state updates on rising edge.
REQ-003 The block SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port: start  input  1  request to begin an operation.
REQ-005 The block SHALL have port: A  input  W  operand A, sampled only on an accepted start.
REQ-006 The block SHALL have port: B  input  W  operand B, sampled only on an accepted start.
REQ-007 The block SHALL have port: cin  input  1  carry-in, sampled only on an accepted start.
REQ-008 The block SHALL have port: ready  output  1  high when a start will be accepted.
REQ-009 The block SHALL have port: done  output  1  one-cycle pulse when the result registers update.
REQ-010 The block SHALL have port: S  output  W  result sum.
REQ-011 The block SHALL have port: cout  output  1  carry out of bit W-1.
REQ-012 The block SHALL have port: overflow  output  1  two's-complement signed overflow of the result.

Function
REQ-013 The block SHALL instantiate exactly one ripple_adder (4-bit) and time-share it across all nibbles; no other adder logic is permitted in the sum path.
REQ-014 The FSM SHALL have three states, IDLE, RUN and DONE; ready = 1 only in IDLE.
REQ-015 In IDLE, start = 1 SHALL latch A, B and cin into internal registers, clear nibble index idx to 0, load the carry register with cin, and enter RUN.
REQ-016 start SHALL be ignored in RUN and DONE, and operand inputs SHALL NOT affect an operation in progress.
REQ-017 In each RUN cycle, the adder SHALL take nibble idx of the latched A and B plus the carry register, write its 4-bit sum into nibble idx of an internal result register, load its cout into the carry register, and increment idx.
REQ-018 After processing nibble NIBBLES-1, the FSM SHALL enter DONE; on that edge S, cout and overflow SHALL load from the internal result, the final carry and the overflow computation.
REQ-019 Overflow SHALL be 1 iff latched A[W-1] equals effective B[W-1] and the result bit [W-1] differs from A[W-1].
REQ-020 done SHALL be 1 for exactly the one DONE cycle; DONE SHALL always go to IDLE on the next edge.
REQ-021 Latency SHALL be fixed: a start accepted at edge t gives done = 1 in the cycle after edge t+NIBBLES; the next start is accepted no earlier than edge t+NIBBLES+2.
REQ-022 S, cout and overflow SHALL hold their values from DONE until the next DONE; they SHALL NOT change during RUN.
REQ-023 A carry out of the top nibble SHALL appear only on cout and SHALL NOT wrap into nibble 0.

Reset
REQ-024 reset = 1 at a rising edge SHALL force state = IDLE, idx = 0, carry = 0, done = 0, S = 0, cout = 0 and overflow = 0; ready SHALL be 1 in the cycle after reset.
REQ-025 Reset SHALL take priority over start and SHALL abort any RUN/DONE operation without producing a done pulse.

Configuration
REQ-026 When macro NIBBLE_SERIAL_SUB_EN is defined, the block SHALL have an extra input port sub (1 bit) sampled with the operands on accept; sub = 1 SHALL invert every latched B nibble (effective B) and load the carry register with 1, ignoring cin, so the result is A - B.
REQ-027 When NIBBLE_SERIAL_SUB_EN is undefined, the sub port SHALL NOT exist and the block SHALL perform addition only (effective B = B).

Verification (NIBBLES = 4)
REQ-028 Scenario: A=0xFFFF, B=0x0001, cin=0, start pulse at edge t -> done = 1 in the cycle after t+4; S = 0x0000, cout = 1, overflow = 0.
REQ-029 Scenario: A=0x7FFF, B=0x0001, cin=0 -> S = 0x8000, cout = 0, overflow = 1; A=0x1234, B=0x4321, cin=1 -> S = 0x5556, cout = 0.
REQ-030 Scenario: start held high continuously; A/B changed every cycle -> operations accepted every 6 cycles; each result matches the operands present at its accept edge only.
REQ-031 Scenario: reset asserted at the second RUN edge, after a prior result S = 0x5556 -> no done pulse; S = 0, ready = 1 in the next cycle; the next operation completes normally.
REQ-032 Scenario (NIBBLE_SERIAL_SUB_EN defined): A=0x0005, B=0x0007, sub=1, cin=0 -> S = 0xFFFE, cout = 0, overflow = 0; A=0x8000, B=0x0001, sub=1 -> S = 0x7FFF, overflow = 1.
